// File: rtl/nios2_gain_update_sequencer.sv
// Turns a commit edge on the CPU update-control word into a click-free gain ramp,
// stepping gain_out by at most STEP per sample_strobe and reporting {done, busy}.
//
// state | meaning
// IDLE  | waiting for a commit edge (or one latched while in DONE)
// RAMP  | stepping gain_out toward target on each sample_strobe
// DONE  | one-cycle completion, sets done_flag
module nios2_gain_update_sequencer #(
    parameter int                GAIN_W     = 8,
    parameter int                STEP       = 1,
    parameter logic [GAIN_W-1:0] RESET_GAIN = 8'h80
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [GAIN_W:0]   update_ctrl,
    input  logic              sample_strobe,
    output logic [GAIN_W-1:0] gain_out,
    output logic              gain_load,
    output logic [1:0]        status
);

    typedef enum logic [1:0] {IDLE, RAMP, DONE} state_t;

    localparam logic [GAIN_W:0]   STEP_V = (GAIN_W+1)'(STEP);
    localparam logic [GAIN_W-1:0] STEP_G = GAIN_W'(STEP);

    state_t            state_q, state_d;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic [GAIN_W-1:0] target_q, target_d;
    logic              commit_prev_q;
    logic              pend_q, pend_d;
    logic              gain_load_q, gain_load_d;
    logic              done_q, done_d;

    logic              req;
    logic [GAIN_W-1:0] new_tgt;
    logic [GAIN_W:0]   diff;
    logic              up;
    logic [GAIN_W-1:0] stepped;
    logic [GAIN_W-1:0] post_gain;

    always_comb begin
        req     = update_ctrl[GAIN_W] & ~commit_prev_q;
        new_tgt = update_ctrl[GAIN_W-1:0];

        up = (target_q >= gain_q);
        if (up) begin
            diff = {1'b0, target_q} - {1'b0, gain_q};
        end else begin
            diff = {1'b0, gain_q} - {1'b0, target_q};
        end
        // Clamping to target when within STEP keeps the add/subtract from wrapping.
        if (diff <= STEP_V) begin
            stepped = target_q;
        end else if (up) begin
            stepped = gain_q + STEP_G;
        end else begin
            stepped = gain_q - STEP_G;
        end
        post_gain = sample_strobe ? stepped : gain_q;

        state_d     = state_q;
        gain_d      = gain_q;
        target_d    = req ? new_tgt : target_q;
        done_d      = req ? 1'b0 : done_q;
        pend_d      = 1'b0;
        gain_load_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (req || pend_q) begin
                    state_d = (target_d == gain_q) ? DONE : RAMP;
                end
            end
            RAMP: begin
                if (sample_strobe) begin
                    gain_d      = stepped;
                    gain_load_d = 1'b1;
                end
                // A same-cycle retarget is judged against the post-step gain.
                if (req) begin
                    state_d = (new_tgt == post_gain) ? DONE : RAMP;
                end else if (post_gain == target_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = ~req;
                pend_d  = req;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            gain_q        <= RESET_GAIN;
            target_q      <= RESET_GAIN;
            commit_prev_q <= 1'b0;
            pend_q        <= 1'b0;
            gain_load_q   <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            gain_q        <= gain_d;
            target_q      <= target_d;
            commit_prev_q <= update_ctrl[GAIN_W];
            pend_q        <= pend_d;
            gain_load_q   <= gain_load_d;
            done_q        <= done_d;
        end
    end

    assign gain_out  = gain_q;
    assign gain_load = gain_load_q;
    assign status    = {done_q, (state_q == RAMP)};

endmodule

// File: tb/tb_nios2_gain_update_sequencer.sv
// Bench for nios2_gain_update_sequencer: one STEP=1 and one STEP=4 instance share stimulus;
// per-cycle vectors queue their expectations, which are popped and checked after each edge.
module tb_nios2_gain_update_sequencer;

    typedef struct {
        logic       rst;
        logic       sel;
        logic [8:0] ctrl;
        logic       strb;
        logic [7:0] gain;
        logic       load;
        logic [1:0] st;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [8:0] ctrl = '0;
    logic       strb = 1'b0;
    logic [7:0] gain1, gain4;
    logic       load1, load4;
    logic [1:0] st1, st4;

    int   n_chk = 0;
    int   n_fail = 0;
    vec_t tbl[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    nios2_gain_update_sequencer #(.GAIN_W(8), .STEP(1), .RESET_GAIN(8'h80)) dut1 (
        .clk(clk), .reset_n(reset_n), .update_ctrl(ctrl), .sample_strobe(strb),
        .gain_out(gain1), .gain_load(load1), .status(st1)
    );

    nios2_gain_update_sequencer #(.GAIN_W(8), .STEP(4), .RESET_GAIN(8'h80)) dut4 (
        .clk(clk), .reset_n(reset_n), .update_ctrl(ctrl), .sample_strobe(strb),
        .gain_out(gain4), .gain_load(load4), .status(st4)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic vec_t mk(input logic rst, input logic sel, input logic [8:0] c, input logic s,
                                input logic [7:0] g, input logic l, input logic [1:0] st);
        vec_t v;
        v.rst = rst; v.sel = sel; v.ctrl = c; v.strb = s; v.gain = g; v.load = l; v.st = st;
        return v;
    endfunction

    task automatic step(input vec_t v, input string tag);
        vec_t e;
        if (v.rst) begin
            reset_n = 1'b0;
            ctrl    = '0;
            strb    = 1'b0;
            @(posedge clk);
            #1;
            reset_n = 1'b1;
        end
        ctrl = v.ctrl;
        strb = v.strb;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, " gain"},   e.sel ? gain4 : gain1, e.gain);
        chk({tag, " load"},   e.sel ? load4 : load1, e.load);
        chk({tag, " status"}, e.sel ? st4 : st1,     e.st);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ramp up 0x80 -> 0x84, STEP=1
        tbl.push_back(mk(1, 0, 9'h084, 0, 8'h80, 0, 2'b00));
        tbl.push_back(mk(0, 0, 9'h184, 0, 8'h80, 0, 2'b01));
        tbl.push_back(mk(0, 0, 9'h184, 1, 8'h81, 1, 2'b01));
        tbl.push_back(mk(0, 0, 9'h184, 0, 8'h81, 0, 2'b01));
        tbl.push_back(mk(0, 0, 9'h184, 1, 8'h82, 1, 2'b01));
        tbl.push_back(mk(0, 0, 9'h184, 1, 8'h83, 1, 2'b01));
        tbl.push_back(mk(0, 0, 9'h184, 1, 8'h84, 1, 2'b00));
        tbl.push_back(mk(0, 0, 9'h184, 0, 8'h84, 0, 2'b10));
        tbl.push_back(mk(0, 0, 9'h184, 1, 8'h84, 0, 2'b10));
        tbl.push_back(mk(0, 0, 9'h084, 0, 8'h84, 0, 2'b10));
        // equal target: no load, never busy
        tbl.push_back(mk(1, 0, 9'h080, 0, 8'h80, 0, 2'b00));
        tbl.push_back(mk(0, 0, 9'h180, 1, 8'h80, 0, 2'b00));
        tbl.push_back(mk(0, 0, 9'h180, 1, 8'h80, 0, 2'b10));
        tbl.push_back(mk(0, 0, 9'h180, 0, 8'h80, 0, 2'b10));
        // req arriving in DONE is served on the following IDLE cycle
        tbl.push_back(mk(1, 0, 9'h181, 0, 8'h80, 0, 2'b01));
        tbl.push_back(mk(0, 0, 9'h081, 0, 8'h80, 0, 2'b01));
        tbl.push_back(mk(0, 0, 9'h081, 1, 8'h81, 1, 2'b00));
        tbl.push_back(mk(0, 0, 9'h183, 0, 8'h81, 0, 2'b00));
        tbl.push_back(mk(0, 0, 9'h183, 0, 8'h81, 0, 2'b01));
        tbl.push_back(mk(0, 0, 9'h183, 1, 8'h82, 1, 2'b01));
        tbl.push_back(mk(0, 0, 9'h183, 1, 8'h83, 1, 2'b00));
        tbl.push_back(mk(0, 0, 9'h183, 0, 8'h83, 0, 2'b10));
        // retarget 0x90 -> 0x81 in the same cycle as strobe 4
        tbl.push_back(mk(1, 0, 9'h190, 0, 8'h80, 0, 2'b01));
        tbl.push_back(mk(0, 0, 9'h090, 1, 8'h81, 1, 2'b01));
        tbl.push_back(mk(0, 0, 9'h090, 1, 8'h82, 1, 2'b01));
        tbl.push_back(mk(0, 0, 9'h090, 1, 8'h83, 1, 2'b01));
        tbl.push_back(mk(0, 0, 9'h181, 1, 8'h84, 1, 2'b01));
        tbl.push_back(mk(0, 0, 9'h181, 1, 8'h83, 1, 2'b01));
        tbl.push_back(mk(0, 0, 9'h181, 1, 8'h82, 1, 2'b01));
        tbl.push_back(mk(0, 0, 9'h181, 1, 8'h81, 1, 2'b00));
        tbl.push_back(mk(0, 0, 9'h181, 0, 8'h81, 0, 2'b10));

        // reset held: outputs pinned regardless of inputs
        reset_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ctrl = 9'($urandom);
            strb = 1'($urandom);
            @(posedge clk);
            #1;
            chk("rst gain1", gain1, 8'h80);
            chk("rst load1", load1, 1'b0);
            chk("rst status1", st1, 2'b00);
            chk("rst gain4", gain4, 8'h80);
            chk("rst status4", st4, 2'b00);
        end

        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // commit held high after the retarget: no further req, done stays set
        for (int i = 0; i < 20; i++) begin
            step(mk(0, 0, 9'h181, 1'(i), 8'h81, 0, 2'b10), "hold");
        end

        // STEP=4 clamp up then long ramp down to zero
        step(mk(1, 1, 9'h186, 0, 8'h80, 0, 2'b01), "clamp0");
        step(mk(0, 1, 9'h186, 1, 8'h84, 1, 2'b01), "clamp1");
        step(mk(0, 1, 9'h186, 1, 8'h86, 1, 2'b00), "clamp2");
        step(mk(0, 1, 9'h086, 0, 8'h86, 0, 2'b10), "clamp3");
        step(mk(0, 1, 9'h100, 0, 8'h86, 0, 2'b01), "down0");
        for (int k = 1; k <= 34; k++) begin
            logic [7:0] eg;
            if (k <= 32)      eg = 8'(8'h86 - 4 * k);
            else if (k == 33) eg = 8'h02;
            else              eg = 8'h00;
            step(mk(0, 1, 9'h100, 1, eg, 1, (k == 34) ? 2'b00 : 2'b01), $sformatf("down%0d", k));
        end
        step(mk(0, 1, 9'h100, 0, 8'h00, 0, 2'b10), "down_done");

        // reset mid-ramp, released with commit still high
        step(mk(1, 0, 9'h1F0, 0, 8'h80, 0, 2'b01), "mid0");
        step(mk(0, 0, 9'h1F0, 1, 8'h81, 1, 2'b01), "mid1");
        step(mk(0, 0, 9'h1F0, 1, 8'h82, 1, 2'b01), "mid2");
        step(mk(0, 0, 9'h1F0, 1, 8'h83, 1, 2'b01), "mid3");
        strb = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        chk("async gain", gain1, 8'h80);
        chk("async load", load1, 1'b0);
        chk("async status", st1, 2'b00);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(mk(0, 0, 9'h1F0, 0, 8'h80, 0, 2'b01), "rel_req");
        step(mk(0, 0, 9'h1F0, 1, 8'h81, 1, 2'b01), "rel_step");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
